matrix_mul_seq: RTL

Sequential, parametrised matrix multiplier: computes MP = A × B over a valid/ready handshake using one time-shared multiply-accumulate datapath instead of a fully unrolled combinational array. It uses the same flat MSB-first element packing as the combinational multiplier, so it can drop in wherever area matters more than latency. It adds a wide accumulator, an output handshake with back-pressure, support for an inner dimension of 1, and optional saturation.

---
 rtl/matrix_mul_pkg.sv | 38 +++
 rtl/matrix_mul_seq_mac_unit.sv | 38 +++
 rtl/matrix_mul_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/matrix_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mul_pkg
// Purpose  : Shared types and sizing helpers for matrix_mul_seq.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // clog2(1)=0, so K=1 naturally yields the 2*word_size minimum
  function automatic int acc_width(input int word_size, input int k);
    return 2 * word_size + clog2(k);
  endfunction

  // LSB of element (row,col) in a flat MSB-first packed matrix
  function automatic int elem_lsb(input int row, input int col, input int rows,
                                  input int cols, input int word_size);
    return (rows * cols - 1 - (row * cols + col)) * word_size;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_mul_seq_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_unit
// Purpose  : Unsigned multiply-accumulate with registered accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_unit #(
  parameter int WORD_SIZE = 32,
  parameter int ACC_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [ACC_W-1:0]     o_acc,
  output logic [ACC_W-1:0]     o_acc_next
);

  logic [2*WORD_SIZE-1:0] w_prod;
  logic [ACC_W-1:0]       r_acc;

  assign w_prod     = {WORD_SIZE'(0), i_a} * {WORD_SIZE'(0), i_b};
  assign o_acc_next = r_acc + ACC_W'(w_prod);
  assign o_acc      = r_acc;

  // Clear wins over enable so the last term of a dot product restarts the sum
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mul_seq
// Purpose  : Time-shared MAC matrix multiplier MP = A x B with valid/ready.
//            Define MATRIX_MUL_SAT_EN to saturate elements instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mul_seq
  import matrix_mul_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int AMATRIXROWNUM = 2,
  parameter int AMATRIXCOLNUM = 2,
  parameter int BMATRIXCOLNUM = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_in_valid,
  output logic                                             o_in_ready,
  input  logic [AMATRIXROWNUM*AMATRIXCOLNUM*WORD_SIZE-1:0] i_a,
  input  logic [AMATRIXCOLNUM*BMATRIXCOLNUM*WORD_SIZE-1:0] i_b,
  output logic                                             o_out_valid,
  input  logic                                             i_out_ready,
  output logic [AMATRIXROWNUM*BMATRIXCOLNUM*WORD_SIZE-1:0] o_mp,
  output logic                                             o_busy
);

  localparam int WS    = WORD_SIZE;
  localparam int M     = AMATRIXROWNUM;
  localparam int K     = AMATRIXCOLNUM;
  localparam int P     = BMATRIXCOLNUM;
  localparam int ACC_W = acc_width(WS, K);
  localparam int IW    = idx_width(M);
  localparam int JW    = idx_width(P);
  localparam int KW    = idx_width(K);
  localparam int AIW   = idx_width(M * K);
  localparam int BIW   = idx_width(K * P);

  state_t               r_state, w_state_nxt;
  logic [IW-1:0]        r_i;
  logic [JW-1:0]        r_j;
  logic [KW-1:0]        r_k;
  logic [M*K*WS-1:0]    r_a;
  logic [K*P*WS-1:0]    r_b;
  logic [M*P*WS-1:0]    r_mp;

  logic [WS-1:0]        w_a_el [M*K];
  logic [WS-1:0]        w_b_el [K*P];
  logic [AIW-1:0]       w_aidx;
  logic [BIW-1:0]       w_bidx;
  logic [WS-1:0]        w_a_sel, w_b_sel;
  logic [ACC_W-1:0]     w_acc, w_acc_next;
  logic [WS-1:0]        w_red;
  logic                 w_cap, w_run, w_last_i, w_last_j, w_last_k, w_wr, w_fin;
  logic [2*ACC_W-WS-1:0] w_unused_bits;

  for (genvar r = 0; r < M; r++) begin : g_a_row
    for (genvar c = 0; c < K; c++) begin : g_a_col
      assign w_a_el[r*K+c] = r_a[elem_lsb(r, c, M, K, WS) +: WS];
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_b_row
    for (genvar c = 0; c < P; c++) begin : g_b_col
      assign w_b_el[r*P+c] = r_b[elem_lsb(r, c, K, P, WS) +: WS];
    end
  end

  assign w_aidx  = AIW'(32'(r_i) * 32'(K) + 32'(r_k));
  assign w_bidx  = BIW'(32'(r_k) * 32'(P) + 32'(r_j));
  assign w_a_sel = w_a_el[w_aidx];
  assign w_b_sel = w_b_el[w_bidx];

  assign w_cap    = (r_state == IDLE) && i_in_valid;
  assign w_run    = (r_state == RUN);
  assign w_last_i = (r_i == IW'(M - 1));
  assign w_last_j = (r_j == JW'(P - 1));
  assign w_last_k = (r_k == KW'(K - 1));
  assign w_wr     = w_run && w_last_k;
  assign w_fin    = w_wr && w_last_j && w_last_i;

  mac_unit #(
    .WORD_SIZE (WS),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_a        (w_a_sel),
    .i_b        (w_b_sel),
    .i_clr      (w_cap || w_wr),
    .i_en       (w_run),
    .o_acc      (w_acc),
    .o_acc_next (w_acc_next)
  );

`ifdef MATRIX_MUL_SAT_EN
  assign w_red = (|w_acc_next[ACC_W-1:WS]) ? {WS{1'b1}} : w_acc_next[WS-1:0];
`else
  assign w_red = w_acc_next[WS-1:0];
`endif
  assign w_unused_bits = {w_acc, w_acc_next[ACC_W-1:WS]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cap)       w_state_nxt = RUN;
      RUN:     if (w_fin)       w_state_nxt = DONE;
      DONE:    if (i_out_ready) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_a <= '0;
      r_b <= '0;
    end else if (w_cap) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_a <= i_a;
      r_b <= i_b;
    end else if (w_run) begin
      if (w_last_k) begin
        r_k <= '0;
        if (w_last_j) begin
          r_j <= '0;
          r_i <= w_last_i ? '0 : r_i + IW'(1);
        end else begin
          r_j <= r_j + JW'(1);
        end
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  // Result elements land one by one as each dot product completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mp <= '0;
    end else if (w_wr) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < P; c++) begin
          if (r_i == IW'(r) && r_j == JW'(c)) begin
            r_mp[elem_lsb(r, c, M, P, WS) +: WS] <= w_red;
          end
        end
      end
    end
  end

  assign o_mp        = r_mp;
  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = w_run;

endmodule
`default_nettype wire
